// File: rtl/hid_mc.sv
// hid_mc: multi-channel HID receiver on the IO MCU byte link.
// Decodes status/keyboard/mouse/joystick/DB9 packets; buffers key events and accumulates mouse motion.
module hid_mc #(
  parameter int NUM_JOY   = 2,
  parameter int NUM_DB9   = 1,
  parameter int KBD_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 data_in_strobe,
  input  logic                 data_in_start,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic [6*NUM_DB9-1:0] db9_port,
  output logic                 irq,
  input  logic                 iack,
  output logic [7:0]           kbd_code,
  output logic                 kbd_valid,
  input  logic                 kbd_ready,
  output logic                 kbd_overflow,
  output logic [1:0]           mouse_btns,
  output logic [7:0]           mouse_dx,
  output logic [7:0]           mouse_dy,
  output logic                 mouse_valid,
  input  logic                 mouse_ack,
  output logic [8*NUM_JOY-1:0] joy_dig,
  output logic [8*NUM_JOY-1:0] joy_ax,
  output logic [8*NUM_JOY-1:0] joy_ay,
  output logic [8*NUM_JOY-1:0] joy_extra,
  output logic [NUM_JOY-1:0]   joy_strobe
);

  localparam int AW = $clog2(KBD_DEPTH);
  localparam int DW = 6 * NUM_DB9;
  localparam int JW = 8 * NUM_JOY;

  localparam logic [7:0] CMD_STATUS = 8'd0;
  localparam logic [7:0] CMD_KBD    = 8'd1;
  localparam logic [7:0] CMD_MOUSE  = 8'd2;
  localparam logic [7:0] CMD_JOY    = 8'd3;
  localparam logic [7:0] CMD_DB9    = 8'd4;

  localparam logic [7:0]  BLOCK_VERSION = 8'h02;
  localparam logic [3:0]  NJ4           = 4'(NUM_JOY);
  localparam logic [3:0]  ND4           = 4'(NUM_DB9);
  localparam logic [AW:0] KBD_FULL_CNT  = (AW + 1)'(KBD_DEPTH);

  // Packet decode state
  logic [7:0]    cmd_q, cmd_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    data_out_q, data_out_d;

  // Keyboard FIFO
  logic [7:0]    kbd_mem [KBD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   kbd_cnt_q, kbd_cnt_d;
  logic          kbd_ovf_q, kbd_ovf_d;
  logic          kbd_push, kbd_wr, kbd_pop, kbd_full;

  // Mouse
  logic [1:0]    btns_q, btns_d;
  logic [7:0]    dx_cap_q, dx_cap_d;
  logic [7:0]    dx_q, dx_d;
  logic [7:0]    dy_q, dy_d;
  logic          mvalid_q, mvalid_d;
  logic          m_acc;

  // Joysticks
  logic [7:0]    dev_q, dev_d;
  logic [JW-1:0] dig_q, dig_d;
  logic [JW-1:0] ax_q, ax_d;
  logic [JW-1:0] ay_q, ay_d;
  logic [JW-1:0] ex_q, ex_d;
  logic [NUM_JOY-1:0] jstb_q, jstb_d;

  // DB9 synchronisers and interrupt
  logic [DW-1:0] sync1_q, sync2_q, sync3_q;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic          db9_change;

  logic byte_v, cmd_v;

  assign cmd_v      = data_in_strobe & data_in_start;
  assign byte_v     = data_in_strobe & ~data_in_start;
  assign kbd_valid  = (kbd_cnt_q != '0);
  assign kbd_full   = (kbd_cnt_q == KBD_FULL_CNT);
  assign kbd_pop    = kbd_valid & kbd_ready;
  assign db9_change = |(sync2_q ^ sync3_q);

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    return s[7:0];
  endfunction

  always_comb begin
    cmd_d      = cmd_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;
    kbd_ovf_d  = kbd_ovf_q;
    kbd_push   = 1'b0;
    kbd_wr     = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    kbd_cnt_d  = kbd_cnt_q;
    btns_d     = btns_q;
    dx_cap_d   = dx_cap_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    mvalid_d   = mvalid_q;
    m_acc      = 1'b0;
    dev_d      = dev_q;
    dig_d      = dig_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    ex_d       = ex_q;
    jstb_d     = '0;
    irq_en_d   = irq_en_q;
    irq_d      = irq_q;

    // A change seen while armed raises irq once and disarms; iack overrides the raise.
    if (irq_en_q && db9_change) begin
      irq_d    = 1'b1;
      irq_en_d = 1'b0;
    end
    if (iack) irq_d = 1'b0;

    if (cmd_v) begin
      cmd_d = data_in;
      idx_d = 4'd0;
    end else if (byte_v) begin
      if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
      data_out_d = 8'h00;
      case (cmd_q)
        CMD_STATUS: begin
          case (idx_q)
            4'd0: data_out_d = BLOCK_VERSION;
            4'd1: data_out_d = {NJ4, ND4};
            4'd2: begin
              data_out_d = {7'b0, kbd_ovf_q};
              kbd_ovf_d  = 1'b0;
            end
            default: data_out_d = 8'h00;
          endcase
        end
        CMD_KBD: kbd_push = (idx_q == 4'd0);
        CMD_MOUSE: begin
          case (idx_q)
            4'd0: btns_d   = data_in[1:0];
            4'd1: dx_cap_d = data_in;
            4'd2: m_acc    = 1'b1;
            default: ;
          endcase
        end
        CMD_JOY: begin
          if (idx_q == 4'd0) begin
            dev_d = data_in;
          end else begin
            // Out-of-range devices match no channel, so their bytes fall through untouched.
            for (int j = 0; j < NUM_JOY; j++) begin
              if (dev_q == 8'(j)) begin
                case (idx_q)
                  4'd1: dig_d[8*j +: 8] = data_in;
                  4'd2: ax_d[8*j +: 8]  = data_in;
                  4'd3: ay_d[8*j +: 8]  = data_in;
                  4'd4: begin
                    ex_d[8*j +: 8] = data_in;
                    jstb_d[j]      = 1'b1;
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        CMD_DB9: begin
          for (int s = 0; s < NUM_DB9; s++) begin
            if (idx_q == 4'(s)) data_out_d = {2'b00, sync2_q[6*s +: 6]};
          end
          if (idx_q == 4'd0) irq_en_d = 1'b1;
        end
        default: ;
      endcase
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    if (kbd_push) begin
      if (!kbd_full || kbd_pop) kbd_wr = 1'b1;
      else                      kbd_ovf_d = 1'b1;
    end
    if (kbd_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (kbd_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    kbd_cnt_d = kbd_cnt_q + {{AW{1'b0}}, kbd_wr} - {{AW{1'b0}}, kbd_pop};

    if (m_acc) begin
      dx_d     = sat_add8(mouse_ack ? 8'h00 : dx_q, dx_cap_q);
      dy_d     = sat_add8(mouse_ack ? 8'h00 : dy_q, data_in);
      mvalid_d = 1'b1;
    end else if (mouse_ack) begin
      dx_d     = 8'h00;
      dy_d     = 8'h00;
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (kbd_wr) kbd_mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      kbd_cnt_q  <= '0;
      kbd_ovf_q  <= 1'b0;
      btns_q     <= '0;
      dx_cap_q   <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      mvalid_q   <= 1'b0;
      dev_q      <= '0;
      dig_q      <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      ex_q       <= '0;
      jstb_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      kbd_cnt_q  <= kbd_cnt_d;
      kbd_ovf_q  <= kbd_ovf_d;
      btns_q     <= btns_d;
      dx_cap_q   <= dx_cap_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      mvalid_q   <= mvalid_d;
      dev_q      <= dev_d;
      dig_q      <= dig_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      ex_q       <= ex_d;
      jstb_q     <= jstb_d;
      sync1_q    <= db9_port;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out     = data_out_q;
  assign irq          = irq_q;
  assign kbd_code     = kbd_valid ? kbd_mem[rd_ptr_q] : 8'h00;
  assign kbd_overflow = kbd_ovf_q;
  assign mouse_btns   = btns_q;
  assign mouse_dx     = dx_q;
  assign mouse_dy     = dy_q;
  assign mouse_valid  = mvalid_q;
  assign joy_dig      = dig_q;
  assign joy_ax       = ax_q;
  assign joy_ay       = ay_q;
  assign joy_extra    = ex_q;
  assign joy_strobe   = jstb_q;

endmodule

// File: tb/tb_hid_mc.sv
// tb_hid_mc: randomized self-checking bench for hid_mc against a packet-level reference model.
module tb_hid_mc;
  localparam int NJ = 2;
  localparam int ND = 1;
  localparam int KD = 8;
  localparam int OW = 38 + 33 * NJ;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          data_in_strobe = 1'b0;
  logic          data_in_start = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic [6*ND-1:0] db9_port = '0;
  logic          irq;
  logic          iack = 1'b0;
  logic [7:0]    kbd_code;
  logic          kbd_valid;
  logic          kbd_ready = 1'b0;
  logic          kbd_overflow;
  logic [1:0]    mouse_btns;
  logic [7:0]    mouse_dx, mouse_dy;
  logic          mouse_valid;
  logic          mouse_ack = 1'b0;
  logic [8*NJ-1:0] joy_dig, joy_ax, joy_ay, joy_extra;
  logic [NJ-1:0] joy_strobe;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model state
  logic [7:0]    kq[$];
  bit            m_ovf = 0;
  int            m_sx = 0, m_sy = 0;
  bit            m_mvalid = 0;
  logic [1:0]    m_btns = '0;
  logic [8*NJ-1:0] m_dig = '0, m_ax = '0, m_ay = '0, m_ex = '0;

  hid_mc #(.NUM_JOY(NJ), .NUM_DB9(ND), .KBD_DEPTH(KD)) dut (
    .clk(clk), .reset_n(reset_n),
    .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
    .data_out(data_out), .db9_port(db9_port), .irq(irq), .iack(iack),
    .kbd_code(kbd_code), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready), .kbd_overflow(kbd_overflow),
    .mouse_btns(mouse_btns), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .mouse_valid(mouse_valid), .mouse_ack(mouse_ack),
    .joy_dig(joy_dig), .joy_ax(joy_ax), .joy_ay(joy_ay), .joy_extra(joy_extra),
    .joy_strobe(joy_strobe)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] all_outs();
    return {data_out, irq, kbd_code, kbd_valid, kbd_overflow, mouse_btns, mouse_dx, mouse_dy,
            mouse_valid, joy_dig, joy_ax, joy_ay, joy_extra, joy_strobe};
  endfunction

  function automatic int clamp8(int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Called at a falling edge; returns at the next falling edge with the byte processed.
  task automatic send_byte(input logic start, input logic [7:0] b);
    data_in_strobe = 1'b1;
    data_in_start  = start;
    data_in        = b;
    @(negedge clk);
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
  endtask

  task automatic mouse_packet(input logic [1:0] b, input logic [7:0] x, input logic [7:0] y,
                              input bit ack_last);
    send_byte(1'b1, 8'd2);
    send_byte(1'b0, {6'b101010, b});
    send_byte(1'b0, x);
    mouse_ack = ack_last;
    send_byte(1'b0, y);
    mouse_ack = 1'b0;
    if (ack_last) begin m_sx = 0; m_sy = 0; end
    m_sx = clamp8(m_sx + int'($signed(x)));
    m_sy = clamp8(m_sy + int'($signed(y)));
    m_btns = b;
    m_mvalid = 1;
    $display("mouse packet btns=%0d dx=%02h dy=%02h ack=%0d", b, x, y, ack_last);
  endtask

  task automatic joy_packet(input logic [7:0] dev, input logic [7:0] f0, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [7:0] f3);
    send_byte(1'b1, 8'd3);
    send_byte(1'b0, dev);
    send_byte(1'b0, f0);
    send_byte(1'b0, f1);
    send_byte(1'b0, f2);
    send_byte(1'b0, f3);
    if (dev < NJ) begin
      m_dig[8*dev +: 8] = f0;
      m_ax[8*dev +: 8]  = f1;
      m_ay[8*dev +: 8]  = f2;
      m_ex[8*dev +: 8]  = f3;
    end
    $display("joy packet dev=%0d %02h %02h %02h %02h", dev, f0, f1, f2, f3);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks_total++;
    if (all_outs() !== '0) $display("FAIL reset_held outs=%h expected 0", all_outs());
    else checks_passed++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks_total++;
    if (all_outs() !== '0) $display("FAIL reset_released outs=%h expected 0", all_outs());
    else checks_passed++;
    $display("reset done");
  endtask

  task automatic test_status();
    logic [7:0] exp_b;
    send_byte(1'b1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      send_byte(1'b0, 8'($urandom));
      exp_b = (i == 0) ? 8'h02 : (i == 1) ? 8'((NJ << 4) | ND) : (i == 2) ? {7'b0, m_ovf} : 8'h00;
      checks_total++;
      if (data_out !== exp_b) $display("FAIL status_idx%0d got=%02h exp=%02h", i, data_out, exp_b);
      else checks_passed++;
      $display("status read idx=%0d data_out=%02h", i, data_out);
    end
  endtask

  task automatic test_kbd_overflow();
    logic [7:0] base;
    base = 8'($urandom_range(0, 200));
    kbd_ready = 1'b0;
    for (int i = 0; i <= KD; i++) begin
      send_byte(1'b1, 8'd1);
      send_byte(1'b0, base + 8'(i));
      if (kq.size() < KD) kq.push_back(base + 8'(i));
      else m_ovf = 1;
      $display("kbd push code=%02h", base + 8'(i));
    end
    checks_total++;
    if (kbd_overflow !== m_ovf) $display("FAIL kbd_ovf_set got=%0b exp=%0b", kbd_overflow, m_ovf);
    else checks_passed++;
    while (kq.size() > 0) begin
      checks_total++;
      if (kbd_valid !== 1'b1 || kbd_code !== kq[0])
        $display("FAIL kbd_pop valid=%0b code=%02h exp=%02h", kbd_valid, kbd_code, kq[0]);
      else checks_passed++;
      kbd_ready = 1'b1;
      @(negedge clk);
      kbd_ready = 1'b0;
      void'(kq.pop_front());
    end
    checks_total++;
    if (kbd_valid !== 1'b0) $display("FAIL kbd_empty valid=%0b exp=0", kbd_valid);
    else checks_passed++;
    send_byte(1'b1, 8'd0);
    repeat (3) send_byte(1'b0, 8'h00);
    checks_total++;
    if (data_out !== 8'h01) $display("FAIL status_ovf_read got=%02h exp=01", data_out);
    else checks_passed++;
    m_ovf = 0;
    checks_total++;
    if (kbd_overflow !== 1'b0) $display("FAIL kbd_ovf_clear got=%0b exp=0", kbd_overflow);
    else checks_passed++;
  endtask

  task automatic test_kbd_random();
    for (int it = 0; it < 30; it++) begin
      logic [7:0] code;
      code = 8'($urandom);
      for (int ph = 0; ph < 2; ph++) begin
        bit rdy, pop, full;
        rdy = ($urandom_range(0, 3) == 0);
        checks_total++;
        if (kbd_valid !== (kq.size() != 0) || (kq.size() != 0 && kbd_code !== kq[0]))
          $display("FAIL kbd_rand_head valid=%0b code=%02h exp_size=%0d", kbd_valid, kbd_code, kq.size());
        else checks_passed++;
        kbd_ready = rdy;
        pop  = rdy && (kq.size() != 0);
        full = (kq.size() == KD);
        if (pop) void'(kq.pop_front());
        if (ph == 1) begin
          if (full && !pop) m_ovf = 1;
          else kq.push_back(code);
        end
        send_byte(ph == 0, (ph == 0) ? 8'd1 : code);
      end
      checks_total++;
      if (kbd_overflow !== m_ovf) $display("FAIL kbd_rand_ovf got=%0b exp=%0b", kbd_overflow, m_ovf);
      else checks_passed++;
      $display("kbd random push code=%02h fifo_size=%0d", code, kq.size());
    end
    kbd_ready = 1'b1;
    repeat (KD + 1) @(negedge clk);
    kbd_ready = 1'b0;
    kq.delete();
  endtask

  task automatic test_mouse();
    mouse_packet(2'b01, 8'h70, 8'h90, 0);
    mouse_packet(2'b10, 8'h70, 8'h90, 0);
    checks_total++;
    if (mouse_dx !== 8'h7F || mouse_dy !== 8'h80 || mouse_valid !== 1'b1 || mouse_btns !== 2'b10)
      $display("FAIL mouse_sat dx=%02h dy=%02h v=%0b b=%0d exp 7f 80 1 2", mouse_dx, mouse_dy, mouse_valid, mouse_btns);
    else checks_passed++;
    mouse_ack = 1'b1;
    @(negedge clk);
    mouse_ack = 1'b0;
    m_sx = 0; m_sy = 0; m_mvalid = 0;
    checks_total++;
    if (mouse_dx !== 8'h00 || mouse_dy !== 8'h00 || mouse_valid !== 1'b0)
      $display("FAIL mouse_ack dx=%02h dy=%02h v=%0b exp 0 0 0", mouse_dx, mouse_dy, mouse_valid);
    else checks_passed++;
    mouse_packet(2'b00, 8'h10, 8'h20, 0);
    mouse_packet(2'b11, 8'h05, 8'hFB, 1);
    checks_total++;
    if (mouse_dx !== 8'h05 || mouse_dy !== 8'hFB || mouse_valid !== 1'b1)
      $display("FAIL mouse_ack_coincide dx=%02h dy=%02h v=%0b exp 05 fb 1", mouse_dx, mouse_dy, mouse_valid);
    else checks_passed++;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mouse_ack = 1'b1;
        @(negedge clk);
        mouse_ack = 1'b0;
        m_sx = 0; m_sy = 0; m_mvalid = 0;
      end
      mouse_packet(2'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      checks_total++;
      if (mouse_dx !== 8'(m_sx) || mouse_dy !== 8'(m_sy) || mouse_valid !== m_mvalid || mouse_btns !== m_btns)
        $display("FAIL mouse_rand dx=%02h dy=%02h v=%0b b=%0d exp %02h %02h %0b %0d",
                 mouse_dx, mouse_dy, mouse_valid, mouse_btns, 8'(m_sx), 8'(m_sy), m_mvalid, m_btns);
      else checks_passed++;
    end
  endtask

  task automatic test_joy();
    logic [7:0] dev, a, b;
    logic [NJ-1:0] es;
    joy_packet(8'd1, 8'h0F, 8'h80, 8'h7F, 8'h01);
    checks_total++;
    if (joy_dig[15:8] !== 8'h0F || joy_ax[15:8] !== 8'h80 || joy_ay[15:8] !== 8'h7F ||
        joy_extra[15:8] !== 8'h01 || joy_strobe !== 2'b10)
      $display("FAIL joy_dev1 dig=%02h ax=%02h ay=%02h ex=%02h stb=%b exp 0f 80 7f 01 10",
               joy_dig[15:8], joy_ax[15:8], joy_ay[15:8], joy_extra[15:8], joy_strobe);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (joy_strobe !== '0) $display("FAIL joy_strobe_pulse got=%b exp=0", joy_strobe);
    else checks_passed++;
    for (int i = 0; i < 8; i++) begin
      dev = (i == 0) ? 8'(NJ) : 8'($urandom_range(0, NJ + 1));
      joy_packet(dev, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      es = '0;
      if (dev < NJ) es[dev] = 1'b1;
      checks_total++;
      if (joy_dig !== m_dig || joy_ax !== m_ax || joy_ay !== m_ay || joy_extra !== m_ex || joy_strobe !== es)
        $display("FAIL joy_rand dev=%0d dig=%h ax=%h ay=%h ex=%h stb=%b exp %h %h %h %h %b",
                 dev, joy_dig, joy_ax, joy_ay, joy_extra, joy_strobe, m_dig, m_ax, m_ay, m_ex, es);
      else checks_passed++;
      @(negedge clk);
    end
    a = 8'($urandom);
    b = 8'($urandom);
    send_byte(1'b1, 8'd3);
    send_byte(1'b0, 8'd0);
    send_byte(1'b0, a);
    send_byte(1'b0, b);
    m_dig[7:0] = a;
    m_ax[7:0]  = b;
    send_byte(1'b1, 8'd0);
    @(negedge clk);
    checks_total++;
    if (joy_dig !== m_dig || joy_ax !== m_ax || joy_strobe !== '0)
      $display("FAIL joy_abandon dig=%h ax=%h stb=%b exp %h %h 0", joy_dig, joy_ax, joy_strobe, m_dig, m_ax);
    else checks_passed++;
    $display("joy abandoned packet dig=%02h ax=%02h", a, b);
  endtask

  task automatic test_irq();
    logic [5:0] v;
    v = 6'($urandom);
    db9_port = v;
    repeat (3) @(negedge clk);
    send_byte(1'b1, 8'd4);
    send_byte(1'b0, 8'h00);
    checks_total++;
    if (data_out !== {2'b00, v}) $display("FAIL db9_readback got=%02h exp=%02h", data_out, {2'b00, v});
    else checks_passed++;
    send_byte(1'b0, 8'h00);
    checks_total++;
    if (data_out !== 8'h00 || irq !== 1'b0) $display("FAIL db9_idx1 got=%02h irq=%0b exp 00 0", data_out, irq);
    else checks_passed++;
    db9_port = db9_port ^ 6'd1;
    repeat (2) @(negedge clk);
    checks_total++;
    if (irq !== 1'b0) $display("FAIL irq_early got=%0b exp=0", irq);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (irq !== 1'b1) $display("FAIL irq_raise got=%0b exp=1", irq);
    else checks_passed++;
    $display("irq raised after db9 toggle");
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    checks_total++;
    if (irq !== 1'b0) $display("FAIL irq_iack got=%0b exp=0", irq);
    else checks_passed++;
    db9_port = db9_port ^ 6'd1;
    repeat (4) @(negedge clk);
    checks_total++;
    if (irq !== 1'b0) $display("FAIL irq_disarmed got=%0b exp=0", irq);
    else checks_passed++;
    send_byte(1'b1, 8'd4);
    send_byte(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checks_total++;
    if (irq !== 1'b0) $display("FAIL irq_rearm_quiet got=%0b exp=0", irq);
    else checks_passed++;
    db9_port = db9_port ^ 6'd1;
    repeat (2) @(negedge clk);
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    checks_total++;
    if (irq !== 1'b0) $display("FAIL irq_iack_wins got=%0b exp=0", irq);
    else checks_passed++;
    repeat (3) @(negedge clk);
    checks_total++;
    if (irq !== 1'b0) $display("FAIL irq_after_iack_wins got=%0b exp=0", irq);
    else checks_passed++;
    $display("irq iack-coincide sequence done");
  endtask

  task automatic test_async_reset();
    logic [7:0] a;
    a = 8'($urandom_range(1, 255));
    send_byte(1'b1, 8'd3);
    send_byte(1'b0, 8'd1);
    send_byte(1'b0, a);
    checks_total++;
    if (joy_dig[15:8] !== a) $display("FAIL joy_partial got=%02h exp=%02h", joy_dig[15:8], a);
    else checks_passed++;
    #2 reset_n = 1'b0;
    #1;
    checks_total++;
    if (all_outs() !== '0) $display("FAIL async_reset outs=%h expected 0", all_outs());
    else checks_passed++;
    @(negedge clk);
    reset_n = 1'b1;
    kq.delete();
    m_ovf = 0; m_sx = 0; m_sy = 0; m_mvalid = 0; m_btns = '0;
    m_dig = '0; m_ax = '0; m_ay = '0; m_ex = '0;
    $display("async reset applied mid-packet");
    joy_packet(8'd0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    checks_total++;
    if (joy_dig !== m_dig || joy_ax !== m_ax || joy_ay !== m_ay || joy_extra !== m_ex || joy_strobe !== 2'b01)
      $display("FAIL post_reset_joy dig=%h ax=%h ay=%h ex=%h stb=%b exp %h %h %h %h 01",
               joy_dig, joy_ax, joy_ay, joy_extra, joy_strobe, m_dig, m_ax, m_ay, m_ex);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_status();
    test_kbd_overflow();
    test_kbd_random();
    test_mouse();
    test_joy();
    test_irq();
    test_async_reset();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
